// File: rtl/rv32i_pkg.sv
// Shared rv32i core constants and the fetch buffer entry layout.
package rv32i_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/rv32i_fetch_unit_if.sv
// Instruction-memory request/response channel and the decode-side output channel.
interface rv32i_fetch_unit_if;
  import rv32i_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );

  // Memory / decode side.
  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );

endinterface

// File: rtl/rv32i_fetch_buffer.sv
// Small FIFO of {pc, instr} entries with synchronous flush; push and pop may
// coincide at any fill level, including full.
module rv32i_fetch_buffer
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  fetch_entry_t                 i_push_data,
  input  logic                         i_pop,
  output fetch_entry_t                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Effective push/pop; a push into a full buffer only lands if the head leaves.
  always_comb begin
    w_do_pop  = i_pop && !o_empty;
    w_do_push = i_push && (!o_full || w_do_pop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/rv32i_fetch_unit.sv
// Fetch front end: owns the PC, issues credit-limited sequential fetches,
// buffers in-order responses for decode and restarts on branch redirects.
module rv32i_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  rv32i_fetch_unit_if.master bus,
  output logic               fetch_fault
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_resp_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_fault;

  logic             w_redirect;
  logic             w_misaligned;
  logic             w_req_valid;
  logic             w_req_fire;
  logic             w_rsp;
  logic             w_rsp_counted;
  logic             w_dropping;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_out_after_rsp;
  logic [CNT_W-1:0] w_out_nxt;
  logic [SUM_W-1:0] w_credit_used;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;

  // A redirect only acts while no fault is latched; later redirects are ignored.
  assign w_redirect   = redirect_valid && !r_fault;
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);

  // Request side: credits cover both in-flight and buffered instructions,
  // so the buffer can never overflow. Only redirect_valid is a comb input.
  always_comb begin
    w_credit_used = SUM_W'(r_outstanding) + SUM_W'(w_count);
    w_req_valid   = rst_n && !r_fault && !redirect_valid &&
                    (w_credit_used < SUM_W'(BUF_DEPTH));
    w_req_fire    = w_req_valid && bus.imem_req_ready;
  end

  // Response side: count in-flight fetches and decide whether to keep the data.
  always_comb begin
    w_rsp           = bus.imem_rsp_valid;
    w_rsp_counted   = w_rsp && (r_outstanding != '0);
    w_out_after_rsp = r_outstanding - CNT_W'(w_rsp_counted);
    w_out_nxt       = w_out_after_rsp + CNT_W'(w_req_fire);
    w_dropping      = (r_drop_cnt != '0);
    w_push          = w_rsp && !w_dropping && !w_redirect && !r_fault;
    w_pop           = !w_empty && bus.out_ready;
    w_push_entry    = '{pc: r_resp_pc, instr: bus.imem_rsp_data};
  end

  // PC, response PC, counters and the sticky fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_fault       <= 1'b0;
    end else begin
      r_outstanding <= w_out_nxt;
      if (w_redirect) begin
        r_pc       <= redirect_pc;
        r_resp_pc  <= redirect_pc;
        r_drop_cnt <= w_out_after_rsp;
        if (w_misaligned) r_fault <= 1'b1;
      end else begin
        if (w_req_fire) r_pc <= r_pc + XLEN'(PC_STEP);
        if (w_rsp && w_dropping)   r_drop_cnt <= r_drop_cnt - CNT_W'(1);
        else if (w_push)           r_resp_pc  <= r_resp_pc + XLEN'(PC_STEP);
      end
    end
  end

  rv32i_fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (w_redirect),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.out_valid      = !w_empty;
  assign bus.out_instr      = w_empty ? '0 : w_head.instr;
  assign bus.out_pc         = w_empty ? '0 : w_head.pc;
  assign fetch_fault        = r_fault;

  // Memory protocol and credit invariants.
  a_rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    w_rsp |-> (r_outstanding != '0));
  a_no_enqueue_to_full: assert property (@(posedge clk) disable iff (!rst_n)
    w_push |-> (!w_full || w_pop));

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit with a latency-configurable memory model.
module tb_rv32i_fetch_unit;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_fault;

  rv32i_fetch_unit_if bus();

  rv32i_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory contents: every address holds a distinct word.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // In-order memory with fixed latency `lat` (1 = respond in the next cycle).
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  pend_t       pend_q[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned n_acc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      pend_q.delete();
    end else begin
      if (bus.imem_rsp_valid && pend_q.size() > 0) void'(pend_q.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        pend_q.push_back('{bus.imem_req_addr, cyc + lat});
        n_acc <= n_acc + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      bus.imem_rsp_valid <= 1'b1;
      bus.imem_rsp_data  <= instr_of(pend_q[0].addr);
    end else begin
      bus.imem_rsp_valid <= 1'b0;
      bus.imem_rsp_data  <= 32'h0;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk1 ({tag, " req_valid"}, bus.imem_req_valid, 1'b0);
    chk1 ({tag, " out_valid"}, bus.out_valid, 1'b0);
    chk1 ({tag, " fault"},     fetch_fault, 1'b0);
    chk32({tag, " out_pc"},    bus.out_pc, 32'h0);
    chk32({tag, " out_instr"}, bus.out_instr, 32'h0);
  endtask

  // Hold reset, then release at a falling edge; cycle 0 starts right after.
  task automatic do_reset(input int unsigned latency, input logic ordy);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    lat            = latency;
    bus.out_ready  = ordy;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 20 && !bus.imem_req_valid; i++) step();
    if (!bus.imem_req_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: req_valid=0, expected 1", name);
    end
  endtask

  task automatic wait_out(input string name);
    for (int i = 0; i < 20 && !bus.out_valid; i++) step();
    if (!bus.out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: out_valid=0, expected 1", name);
    end
  endtask

  typedef struct {
    logic        out_ready;
    logic        redir;
    logic [31:0] redir_pc;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_ov;
    logic [31:0] exp_pc;
  } vec_t;

  function automatic vec_t mkv(input logic redir, input logic [31:0] rpc,
                               input logic rv, input logic [31:0] addr,
                               input logic ov, input logic [31:0] pc);
    vec_t v;
    v.out_ready = 1'b1;
    v.redir     = redir;
    v.redir_pc  = rpc;
    v.exp_rv    = rv;
    v.exp_addr  = addr;
    v.exp_ov    = ov;
    v.exp_pc    = pc;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    int unsigned acc0;

    // Per-cycle vectors, 1-cycle memory, decode always ready.
    vecs[0]  = mkv(1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h0);
    vecs[1]  = mkv(1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h0);
    vecs[2]  = mkv(1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h000);
    vecs[3]  = mkv(1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h004);
    vecs[4]  = mkv(1'b0, 32'h0,   1'b1, 32'h00C, 1'b0, 32'h0);
    vecs[5]  = mkv(1'b1, 32'h200, 1'b0, 32'h0,   1'b1, 32'h008);
    vecs[6]  = mkv(1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0);
    vecs[7]  = mkv(1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h0);
    vecs[8]  = mkv(1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200);
    vecs[9]  = mkv(1'b1, 32'h300, 1'b0, 32'h0,   1'b1, 32'h204);
    vecs[10] = mkv(1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h0);
    vecs[11] = mkv(1'b0, 32'h0,   1'b1, 32'h304, 1'b0, 32'h0);
    vecs[12] = mkv(1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h300);

    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b0;
    #1;
    check_idle("reset");

    // Streaming with coincident-response redirect and masked-request redirect.
    do_reset(1, 1'b1);
    for (int i = 0; i < 13; i++) begin
      if (i != 0) @(negedge clk);
      bus.out_ready  = vecs[i].out_ready;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].redir_pc;
      #1;
      chk1($sformatf("row%0d req_valid", i), bus.imem_req_valid, vecs[i].exp_rv);
      if (vecs[i].exp_rv)
        chk32($sformatf("row%0d req_addr", i), bus.imem_req_addr, vecs[i].exp_addr);
      chk1($sformatf("row%0d out_valid", i), bus.out_valid, vecs[i].exp_ov);
      if (vecs[i].exp_ov) begin
        chk32($sformatf("row%0d out_pc", i), bus.out_pc, vecs[i].exp_pc);
        chk32($sformatf("row%0d out_instr", i), bus.out_instr, instr_of(vecs[i].exp_pc));
      end
    end
    redirect_valid = 1'b0;

    // Backpressure: only two credits, then drain and resume at 0x8.
    do_reset(1, 1'b0);
    acc0 = n_acc;
    repeat (6) step();
    chk32("bp accepted", n_acc - acc0, 32'd2);
    chk1 ("bp req_valid", bus.imem_req_valid, 1'b0);
    chk1 ("bp out_valid", bus.out_valid, 1'b1);
    chk32("bp out_pc", bus.out_pc, 32'h0);
    bus.out_ready = 1'b1;
    #1;
    chk32("bp drain0 pc", bus.out_pc, 32'h0);
    step();
    chk32("bp drain1 pc", bus.out_pc, 32'h4);
    chk32("bp drain1 instr", bus.out_instr, instr_of(32'h4));
    chk1 ("bp resume valid", bus.imem_req_valid, 1'b1);
    chk32("bp resume addr", bus.imem_req_addr, 32'h8);

    // Redirect with two fetches in flight on a 3-cycle memory.
    do_reset(3, 1'b1);
    acc0 = n_acc;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk32("rd3 in flight", n_acc - acc0, 32'd2);
    chk1 ("rd3 req masked", bus.imem_req_valid, 1'b0);
    step();
    redirect_valid = 1'b0;
    #1;
    wait_req("rd3 req");
    chk32("rd3 first addr", bus.imem_req_addr, 32'h100);
    wait_out("rd3 out0");
    chk32("rd3 out0 pc", bus.out_pc, 32'h100);
    chk32("rd3 out0 instr", bus.out_instr, instr_of(32'h100));
    step();
    wait_out("rd3 out1");
    chk32("rd3 out1 pc", bus.out_pc, 32'h104);

    // Misaligned redirect: sticky fault, stale responses dropped, later redirect ignored.
    do_reset(3, 1'b1);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    #1;
    chk1("mis fault before", fetch_fault, 1'b0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk1("mis fault", fetch_fault, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
      end else begin
        redirect_valid = 1'b0;
      end
      #1;
      chk1($sformatf("mis c%0d fault", i), fetch_fault, 1'b1);
      chk1($sformatf("mis c%0d req_valid", i), bus.imem_req_valid, 1'b0);
      chk1($sformatf("mis c%0d out_valid", i), bus.out_valid, 1'b0);
      step();
    end
    redirect_valid = 1'b0;

    // Asynchronous reset between clock edges while streaming.
    do_reset(1, 1'b1);
    repeat (5) step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1 ("async restart valid", bus.imem_req_valid, 1'b1);
    chk32("async restart addr", bus.imem_req_addr, 32'h0);
    wait_out("async out0");
    chk32("async out0 pc", bus.out_pc, 32'h0);
    chk32("async out0 instr", bus.out_instr, instr_of(32'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
